// File: rtl/instr_word_encoder.sv
`timescale 1ns/1ps
// instr_word_encoder
// Packs symbolic instruction requests into 32-bit MIPS instruction words
// and writes them one after another into instruction memory. The opcode,
// funct and rt codes match what the Controller decodes, so a word encoded
// here decodes back to the requested operation.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             one-cycle pulse that begins a program load
//   in_valid/in_ready request handshake; in_last marks the final request
//   op_sel            operation select (0..29 supported, 30..31 flagged)
//   rs, rt, rd, shamt register and shift fields
//   imm, target       immediate / branch offset and jump target
//   mem_wr_en         instruction-memory write strobe
//   mem_wr_addr       byte address of the word being written
//   mem_wr_data       encoded instruction word
//   count             words written since start
//   err               sticky flag, set by an unsupported op_sel
//   done              one-cycle pulse after the final word is written
//
// Optional feature (macro INSTR_ENC_HALT_ON_FULL_EN):
//   defined   - once count reaches DEPTH the load stalls with in_ready low,
//               err is set by any valid request held against the stall, and
//               a start pulse restarts the load
//   undefined - no stall; the address wraps back to BASE_ADDR every DEPTH
//               words and count wraps modulo 2^16

module instr_word_encoder #(
  parameter int          ADDR_W    = 32,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned ADDR_STEP = 4,
  parameter int          DEPTH     = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [4:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  output logic [15:0]       count,
  output logic              err,
  output logic              done
);

  localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_ptr;
  logic [SLOT_W-1:0] slot;
  logic              accept;
  logic              restart;
  logic              stall_err;
  logic [31:0]       word;
  logic              word_ok;

  // slot tracks the position inside the DEPTH-word region so the address
  // can wrap to BASE_ADDR independently of the 16-bit count
`ifdef INSTR_ENC_HALT_ON_FULL_EN
  logic full;
  assign full      = (count == 16'(DEPTH));
  assign in_ready  = (state == LOAD) && !full;
  assign stall_err = (state == LOAD) && full && in_valid;
  // a stalled load can only be left by reset or a fresh start
  assign restart   = start && ((state == IDLE) || ((state == LOAD) && full));
`else
  assign in_ready  = (state == LOAD);
  assign stall_err = 1'b0;
  assign restart   = start && (state == IDLE);
`endif

  assign accept = in_valid && in_ready;

  // Word packing: only the fields a format uses reach the word; everything
  // else is replaced by constant zeros (or the fixed rt code for REGIMM)
  always_comb begin
    word    = '0;
    word_ok = 1'b1;
    case (op_sel)
      5'd0:  word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100000};
      5'd1:  word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100010};
      5'd2:  word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100100};
      5'd3:  word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100101};
      5'd4:  word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100111};
      5'd5:  word = {6'b000000, rs, rt, rd, 5'b00000, 6'b100110};
      5'd6:  word = {6'b000000, rs, rt, rd, 5'b00000, 6'b101010};
      5'd7:  word = {6'b000000, 5'b00000, rt, rd, shamt, 6'b000000};
      5'd8:  word = {6'b000000, 5'b00000, rt, rd, shamt, 6'b000010};
      5'd9:  word = {6'b000000, rs, 15'd0, 6'b001000};
      5'd10: word = {6'b011100, rs, rt, rd, 5'b00000, 6'b000010};
      5'd11: word = {6'b001000, rs, rt, imm};
      5'd12: word = {6'b001100, rs, rt, imm};
      5'd13: word = {6'b001101, rs, rt, imm};
      5'd14: word = {6'b001110, rs, rt, imm};
      5'd15: word = {6'b001010, rs, rt, imm};
      5'd16: word = {6'b100011, rs, rt, imm};
      5'd17: word = {6'b101011, rs, rt, imm};
      5'd18: word = {6'b100000, rs, rt, imm};
      5'd19: word = {6'b100001, rs, rt, imm};
      5'd20: word = {6'b101000, rs, rt, imm};
      5'd21: word = {6'b101001, rs, rt, imm};
      5'd22: word = {6'b000100, rs, rt, imm};
      5'd23: word = {6'b000101, rs, rt, imm};
      5'd24: word = {6'b000111, rs, 5'b00000, imm};
      5'd25: word = {6'b000110, rs, 5'b00000, imm};
      5'd26: word = {6'b000001, rs, 5'b00000, imm};
      5'd27: word = {6'b000001, rs, 5'b00001, imm};
      5'd28: word = {6'b000010, target};
      5'd29: word = {6'b000011, target};
      default: word_ok = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; FLUSH covers the cycle in which the final write is
  // on the memory port
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (restart) state_next = LOAD;
      LOAD:    if (accept && in_last) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write port, address pointer, count and flags. The write strobe is a
  // single-cycle pulse following each accepted supported request; done is
  // registered out of the DONE state so it lands after the final write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      count       <= '0;
      err         <= 1'b0;
      done        <= 1'b0;
      addr_ptr    <= ADDR_W'(BASE_ADDR);
      slot        <= '0;
    end else begin
      mem_wr_en <= 1'b0;
      done      <= (state == DONE);
      if (restart) begin
        addr_ptr <= ADDR_W'(BASE_ADDR);
        slot     <= '0;
        count    <= '0;
        err      <= 1'b0;
      end else begin
        if (accept) begin
          if (word_ok) begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= addr_ptr;
            mem_wr_data <= word;
            count       <= count + 16'd1;
            if (slot == SLOT_W'(DEPTH - 1)) begin
              slot     <= '0;
              addr_ptr <= ADDR_W'(BASE_ADDR);
            end else begin
              slot     <= slot + SLOT_W'(1);
              addr_ptr <= addr_ptr + ADDR_W'(ADDR_STEP);
            end
          end else begin
            err <= 1'b1;
          end
        end
        if (stall_err) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_word_encoder.sv
`timescale 1ns/1ps
// tb_instr_word_encoder
// Self-checking bench for instr_word_encoder built with DEPTH=4 so the
// full/wrap boundary is reachable. Expected words are pushed to a queue as
// each request is accepted and popped by a write monitor on the falling
// edge. Expectations for the full-region case follow
// INSTR_ENC_HALT_ON_FULL_EN.

module tb_instr_word_encoder;

  localparam int DEPTH_TB = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [4:0]  op_sel;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [15:0] count;
  logic        err;
  logic        done;

  exp_t        q[$];
  exp_t        monExp;
  logic [31:0] expAddr;
  int          expSlot;
  int          expCount;
  int          nCompared;
  int          nMismatched;

  instr_word_encoder #(
    .ADDR_W   (32),
    .BASE_ADDR(0),
    .ADDR_STEP(4),
    .DEPTH    (DEPTH_TB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .op_sel     (op_sel),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .imm        (imm),
    .target     (target),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .count      (count),
    .err        (err),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every strobe must match the oldest outstanding request
  always @(negedge clk) begin
    if (rst_n && mem_wr_en) begin
      nCompared++;
      if (q.size() == 0) begin
        nMismatched++;
        $display("[TB] FAIL write_unexpected: got addr=%h data=%h, required no write",
                 mem_wr_addr, mem_wr_data);
      end else begin
        monExp = q.pop_front();
        if (mem_wr_addr !== monExp.addr || mem_wr_data !== monExp.data) begin
          nMismatched++;
          $display("[TB] FAIL write_word: got addr=%h data=%h, required addr=%h data=%h",
                   mem_wr_addr, mem_wr_data, monExp.addr, monExp.data);
        end
      end
    end
  end

  task automatic doStart();
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    expAddr  = 32'd0;
    expSlot  = 0;
    expCount = 0;
  endtask

  // Drives one request, waits (bounded) for the handshake and records the
  // expected write; returns on the falling edge after the accepting edge
  task automatic sendBeat(input logic [4:0] op, input logic [4:0] vRs,
                          input logic [4:0] vRt, input logic [4:0] vRd,
                          input logic [4:0] vSh, input logic [15:0] vImm,
                          input logic [25:0] vTgt, input logic last,
                          input logic [31:0] expWord, input logic writes);
    int waitCycles;
    waitCycles = 0;
    op_sel   = op;
    rs       = vRs;
    rt       = vRt;
    rd       = vRd;
    shamt    = vSh;
    imm      = vImm;
    target   = vTgt;
    in_last  = last;
    in_valid = 1'b1;
    while (!in_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL handshake_timeout: got in_ready=0 for 20 cycles, required 1");
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    if (writes) begin
      q.push_back('{addr: expAddr, data: expWord});
      expCount++;
      if (expSlot == DEPTH_TB - 1) begin
        expSlot = 0;
        expAddr = 32'd0;
      end else begin
        expSlot++;
        expAddr = expAddr + 32'd4;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
    end
    nCompared++;
    if (!done) begin
      nMismatched++;
      $display("[TB] FAIL %s_done: got done=0 after 12 cycles, required 1", name);
    end
    @(negedge clk);
    nCompared++;
    if (q.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL %s_pending: got %0d writes outstanding, required 0", name, q.size());
    end
    nCompared++;
    if (count !== 16'(expCount)) begin
      nMismatched++;
      $display("[TB] FAIL %s_count: got %0d, required %0d", name, count, expCount);
    end
  endtask

  task automatic test_reset();
    #2;
    nCompared += 7;
    if (in_ready !== 1'b0)    begin nMismatched++; $display("[TB] FAIL rst_in_ready: got %b, required 0", in_ready); end
    if (mem_wr_en !== 1'b0)   begin nMismatched++; $display("[TB] FAIL rst_wr_en: got %b, required 0", mem_wr_en); end
    if (mem_wr_addr !== 32'd0) begin nMismatched++; $display("[TB] FAIL rst_wr_addr: got %h, required 0", mem_wr_addr); end
    if (mem_wr_data !== 32'd0) begin nMismatched++; $display("[TB] FAIL rst_wr_data: got %h, required 0", mem_wr_data); end
    if (count !== 16'd0)      begin nMismatched++; $display("[TB] FAIL rst_count: got %0d, required 0", count); end
    if (err !== 1'b0)         begin nMismatched++; $display("[TB] FAIL rst_err: got %b, required 0", err); end
    if (done !== 1'b0)        begin nMismatched++; $display("[TB] FAIL rst_done: got %b, required 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Unused shamt/imm/target carry garbage that must not reach the word
  task automatic test_single();
    doStart();
    sendBeat(5'd0, 5'd1, 5'd2, 5'd3, 5'd7, 16'hABCD, 26'h3FFFFFF, 1'b1, 32'h00221820, 1'b1);
    nCompared += 3;
    if (mem_wr_en !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_wr_en: got %b, required 1", mem_wr_en); end
    if (count !== 16'd1)    begin nMismatched++; $display("[TB] FAIL single_count: got %0d, required 1", count); end
    if (in_ready !== 1'b0)  begin nMismatched++; $display("[TB] FAIL single_ready_after_last: got %b, required 0", in_ready); end
    @(negedge clk);
    nCompared++;
    if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_done_early: got %b, required 0", done); end
    @(negedge clk);
    nCompared++;
    if (done !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_done_pulse: got %b, required 1", done); end
    @(negedge clk);
    nCompared++;
    if (done !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_done_width: got %b, required 0", done); end
    nCompared++;
    if (q.size() != 0) begin nMismatched++; $display("[TB] FAIL single_pending: got %0d, required 0", q.size()); end
  endtask

  task automatic test_back_to_back();
    doStart();
    sendBeat(5'd11, 5'd0, 5'd8, 5'd31, 5'd31, 16'h0005, 26'h1234567, 1'b0, 32'h20080005, 1'b1);
    sendBeat(5'd27, 5'd4, 5'd17, 5'd9, 5'd2, 16'hFFFE, 26'h0, 1'b0, 32'h0481FFFE, 1'b1);
    sendBeat(5'd28, 5'd6, 5'd7, 5'd8, 5'd9, 16'h7777, 26'h0000010, 1'b1, 32'h08000010, 1'b1);
    waitDone("b2b");
  endtask

  task automatic test_unsupported();
    doStart();
    sendBeat(5'd31, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1111, 26'h1, 1'b0, 32'h0, 1'b0);
    sendBeat(5'd16, 5'd29, 5'd9, 5'd0, 5'd0, 16'h0004, 26'h0, 1'b1, 32'h8FA90004, 1'b1);
    waitDone("unsup");
    nCompared++;
    if (err !== 1'b1) begin nMismatched++; $display("[TB] FAIL unsup_err_sticky: got %b, required 1", err); end
    doStart();
    nCompared++;
    if (err !== 1'b0) begin nMismatched++; $display("[TB] FAIL unsup_err_clear: got %b, required 0", err); end
    sendBeat(5'd30, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0, 1'b0);
    waitDone("unsup_last");
    nCompared++;
    if (err !== 1'b1) begin nMismatched++; $display("[TB] FAIL unsup_last_err: got %b, required 1", err); end
  endtask

  task automatic test_formats();
    doStart();
    sendBeat(5'd1,  5'd5,  5'd6,  5'd7,  5'd9,  16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h00A63822, 1'b1);
    sendBeat(5'd9,  5'd31, 5'd5,  5'd6,  5'd3,  16'hFFFF, 26'h3FFFFFF, 1'b0, 32'h03E00008, 1'b1);
    sendBeat(5'd10, 5'd1,  5'd2,  5'd3,  5'd31, 16'h0F0F, 26'h0, 1'b0, 32'h70221802, 1'b1);
    sendBeat(5'd17, 5'd29, 5'd31, 5'd4,  5'd4,  16'hFFFC, 26'h0, 1'b1, 32'hAFBFFFFC, 1'b1);
    waitDone("fmt_a");
    doStart();
    sendBeat(5'd29, 5'd7,  5'd7,  5'd7,  5'd7,  16'hFFFF, 26'h0000100, 1'b0, 32'h0C000100, 1'b1);
    sendBeat(5'd26, 5'd4,  5'd9,  5'd3,  5'd3,  16'h0008, 26'h3FFFFFF, 1'b0, 32'h04800008, 1'b1);
    sendBeat(5'd24, 5'd3,  5'd7,  5'd1,  5'd1,  16'h0002, 26'h0, 1'b0, 32'h1C600002, 1'b1);
    sendBeat(5'd4,  5'd8,  5'd9,  5'd10, 5'd21, 16'hFFFF, 26'h0, 1'b1, 32'h01095027, 1'b1);
    waitDone("fmt_b");
  endtask

  task automatic test_toggle();
    doStart();
    for (int i = 0; i < 3; i++) begin
      sendBeat(5'd7, 5'd5, 5'd2, 5'd2, 5'd4, 16'hBEEF, 26'h0, (i == 2), 32'h00021100, 1'b1);
      if (i < 2) @(negedge clk);
    end
    waitDone("toggle");
  endtask

  task automatic test_full();
    doStart();
    for (int i = 0; i < DEPTH_TB; i++) begin
      sendBeat(5'd0, 5'(i), 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0,
               {6'b0, 5'(i), 5'd2, 5'd3, 5'd0, 6'b100000}, 1'b1);
    end
`ifdef INSTR_ENC_HALT_ON_FULL_EN
    nCompared++;
    if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL full_stall_ready: got %b, required 0", in_ready); end
    op_sel   = 5'd0;
    in_last  = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    nCompared += 3;
    if (err !== 1'b1)      begin nMismatched++; $display("[TB] FAIL full_stall_err: got %b, required 1", err); end
    if (count !== 16'd4)   begin nMismatched++; $display("[TB] FAIL full_stall_count: got %0d, required 4", count); end
    if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL full_stall_hold: got %b, required 0", in_ready); end
    doStart();
    nCompared++;
    if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL full_restart_ready: got %b, required 1", in_ready); end
    sendBeat(5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 32'h00221824, 1'b1);
    waitDone("full_restart");
`else
    sendBeat(5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 32'h00221824, 1'b1);
    waitDone("full_wrap");
    nCompared++;
    if (err !== 1'b0) begin nMismatched++; $display("[TB] FAIL full_wrap_err: got %b, required 0", err); end
`endif
  endtask

  task automatic test_reset_mid();
    doStart();
    op_sel   = 5'd0;
    rs       = 5'd1;
    rt       = 5'd2;
    rd       = 5'd3;
    shamt    = 5'd0;
    in_last  = 1'b0;
    in_valid = 1'b1;
    nCompared++;
    if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL rstmid_ready: got %b, required 1", in_ready); end
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    nCompared += 5;
    if (mem_wr_en !== 1'b0)    begin nMismatched++; $display("[TB] FAIL rstmid_wr_en: got %b, required 0", mem_wr_en); end
    if (mem_wr_data !== 32'd0) begin nMismatched++; $display("[TB] FAIL rstmid_wr_data: got %h, required 0", mem_wr_data); end
    if (mem_wr_addr !== 32'd0) begin nMismatched++; $display("[TB] FAIL rstmid_wr_addr: got %h, required 0", mem_wr_addr); end
    if (count !== 16'd0)       begin nMismatched++; $display("[TB] FAIL rstmid_count: got %0d, required 0", count); end
    if (in_ready !== 1'b0)     begin nMismatched++; $display("[TB] FAIL rstmid_ready_low: got %b, required 0", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    nCompared++;
    if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstmid_needs_start: got %b, required 0", in_ready); end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    expAddr     = 32'd0;
    expSlot     = 0;
    expCount    = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    op_sel      = 5'd0;
    rs          = 5'd0;
    rt          = 5'd0;
    rd          = 5'd0;
    shamt       = 5'd0;
    imm         = 16'd0;
    target      = 26'd0;
    test_reset();
    test_single();
    test_back_to_back();
    test_unsupported();
    test_formats();
    test_toggle();
    test_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
